// File: rtl/hot_water_arb_pkg.sv
// Shared definitions for the hot-water arbiter: FSM state encoding,
// default parameter values and the index-width helper.
package hot_water_arb_pkg;

  // Defaults for a four-washer installation.
  localparam int HWA_N_REQ_DEF          = 4;
  localparam int HWA_CNT_W_DEF          = 8;
  localparam int HWA_MAX_HOLD_DEF       = 40;
  localparam int HWA_RECOVER_CYCLES_DEF = 4;

  // State codes kept as plain constants so older tools and scripts can match them.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_GRANT   = ST_GRANT,
    S_RECOVER = ST_RECOVER
  } hwa_state_e;

  // Bits needed to hold an index into n requesters (at least one).
  function automatic int hwa_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hot_water_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first set bit of i_mask
// found searching i_last+1, i_last+2, ... with wrap-around.
module hot_water_arbiter_rr_picker
  import hot_water_arb_pkg::*;
#(
  parameter int N  = HWA_N_REQ_DEF,
  parameter int IW = hwa_idx_w(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  int w_best;

  // Keep the candidate with the smallest forward distance from i_last.
  always_comb begin
    w_best  = N;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (i_mask[j] && (((j + N - 1 - int'(i_last)) % N) < w_best)) begin
        w_best  = (j + N - 1 - int'(i_last)) % N;
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hot_water_arbiter.sv
// Round-robin arbiter sharing one hot-water heater line between washers.
// Enforces a maximum hold per grant and a heater recovery gap between grants.
// Optional build macro HOT_WATER_ARB_URGENT_EN adds an urgent input whose
// requesters win arbitration first and get a doubled hold limit.
module hot_water_arbiter
  import hot_water_arb_pkg::*;
#(
  parameter int N_REQ          = HWA_N_REQ_DEF,
  parameter int CNT_W          = HWA_CNT_W_DEF,
  parameter int MAX_HOLD       = HWA_MAX_HOLD_DEF,
  parameter int RECOVER_CYCLES = HWA_RECOVER_CYCLES_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           power,
  input  logic [N_REQ-1:0]               req,
`ifdef HOT_WATER_ARB_URGENT_EN
  input  logic [N_REQ-1:0]               urgent,
`endif
  output logic [N_REQ-1:0]               grant,
  output logic                           heater_on,
  output logic                           recovering,
  output logic [N_REQ-1:0]               timeout_pulse,
  output logic [hwa_idx_w(N_REQ)-1:0]    grant_id
);

  localparam int IW          = hwa_idx_w(N_REQ);
  localparam int CNT_MAX_I   = (1 << CNT_W) - 1;
  localparam int HOLD_URG_I  = (2 * MAX_HOLD > CNT_MAX_I) ? CNT_MAX_I : 2 * MAX_HOLD;
  localparam logic [CNT_W-1:0] HOLD_NORM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_URG  = CNT_W'(HOLD_URG_I);
  // With no recovery time the FSM still spends one cycle in RECOVER.
  localparam logic [CNT_W-1:0] REC_LAST  =
    (RECOVER_CYCLES == 0) ? '0 : CNT_W'(RECOVER_CYCLES - 1);

  hwa_state_e       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_tp;
  logic [IW-1:0]    r_id;
  logic [IW-1:0]    r_last;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] r_rec;
  logic             r_recovering;
  logic             r_urg;

  logic [N_REQ-1:0] w_mask;
  logic             w_urg_hit;
  logic             w_pick_vld;
  logic [IW-1:0]    w_pick_idx;
  logic [CNT_W-1:0] w_hold_lim;

`ifdef HOT_WATER_ARB_URGENT_EN
  assign w_urg_hit = |(req & urgent);
  assign w_mask    = w_urg_hit ? (req & urgent) : req;
`else
  assign w_urg_hit = 1'b0;
  assign w_mask    = req;
`endif

  assign w_hold_lim = r_urg ? HOLD_URG : HOLD_NORM;

  hot_water_arbiter_rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .i_mask  (w_mask),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  // Arbitration FSM: IDLE picks a washer, GRANT times the hold, RECOVER lets the heater reheat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_tp         <= '0;
      r_id         <= '0;
      r_last       <= IW'(N_REQ - 1);
      r_hold       <= '0;
      r_rec        <= '0;
      r_recovering <= 1'b0;
      r_urg        <= 1'b0;
    end else begin
      r_tp <= '0;
      if (!power) begin
        // Plant off: drop everything but remember who was served last.
        r_state      <= S_IDLE;
        r_grant      <= '0;
        r_hold       <= '0;
        r_rec        <= '0;
        r_recovering <= 1'b0;
        r_urg        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pick_vld) begin
              r_grant <= N_REQ'(1) << w_pick_idx;
              r_id    <= w_pick_idx;
              r_last  <= w_pick_idx;
              r_hold  <= CNT_W'(1);
              r_urg   <= w_urg_hit;
              r_state <= S_GRANT;
            end
          end
          S_GRANT: begin
            if (!req[r_id]) begin
              // Normal release wins even when the hold limit is reached this cycle.
              r_grant      <= '0;
              r_hold       <= '0;
              r_rec        <= '0;
              r_recovering <= 1'b1;
              r_state      <= S_RECOVER;
            end else if (r_hold == w_hold_lim) begin
              r_grant      <= '0;
              r_tp         <= r_grant;
              r_hold       <= '0;
              r_rec        <= '0;
              r_recovering <= 1'b1;
              r_state      <= S_RECOVER;
            end else if (r_hold != '1) begin
              r_hold <= r_hold + 1'b1;
            end
          end
          S_RECOVER: begin
            if (r_rec == REC_LAST) begin
              r_rec        <= '0;
              r_recovering <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_rec <= r_rec + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign grant         = r_grant;
  assign heater_on     = |r_grant;
  assign recovering    = r_recovering;
  assign timeout_pulse = r_tp;
  assign grant_id      = r_id;

endmodule

// File: tb/tb_hot_water_arbiter.sv
// Testbench for hot_water_arbiter (N_REQ=4, MAX_HOLD=10, RECOVER_CYCLES=3).
// Reference model: ownership / hold count / cooldown count per washer,
// advanced once per clock edge from the rules of the arbiter's behaviour.
module tb_hot_water_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int MH = 10;
  localparam int RC = 3;
  localparam int IW = 2;
  localparam int VW = 2 * N + IW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          power;
  logic [N-1:0]  req;
`ifdef HOT_WATER_ARB_URGENT_EN
  logic [N-1:0]  urgent;
`endif
  logic [N-1:0]  grant;
  logic          heater_on;
  logic          recovering;
  logic [N-1:0]  timeout_pulse;
  logic [IW-1:0] grant_id;

  wire [VW-1:0] got = {grant, grant_id, heater_on, recovering, timeout_pulse};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int           m_owner;
  int           m_held;
  int           m_cool;
  int           m_last;
  int           m_id;
  int           m_lim;
  logic [N-1:0] m_tp;

  hot_water_arbiter #(
    .N_REQ          (N),
    .CNT_W          (CW),
    .MAX_HOLD       (MH),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .power         (power),
    .req           (req),
`ifdef HOT_WATER_ARB_URGENT_EN
    .urgent        (urgent),
`endif
    .grant         (grant),
    .heater_on     (heater_on),
    .recovering    (recovering),
    .timeout_pulse (timeout_pulse),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  // Grant must never be multi-hot.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_total++;
      assert ($onehot0(grant)) n_pass++;
      else $display("FAIL onehot0_grant: got=%b required at most one bit", grant);
    end
  end

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_cool  = 0;
    m_last  = N - 1;
    m_id    = 0;
    m_lim   = MH;
    m_tp    = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] cand;
    m_tp = '0;
    if (!power) begin
      m_owner = -1;
      m_held  = 0;
      m_cool  = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_cool  = (RC > 0) ? RC : 1;
      end else if (m_held == m_lim) begin
        m_tp[m_owner] = 1'b1;
        m_owner = -1;
        m_cool  = (RC > 0) ? RC : 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      cand  = req;
      m_lim = MH;
`ifdef HOT_WATER_ARB_URGENT_EN
      if ((req & urgent) != '0) begin
        cand  = req & urgent;
        m_lim = (2 * MH > (1 << CW) - 1) ? (1 << CW) - 1 : 2 * MH;
      end
`endif
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && cand[(m_last + k) % N]) m_owner = (m_last + k) % N;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_id   = m_owner;
        m_held = 1;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    return {g, IW'(m_id), |g, (m_cool > 0), m_tp};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    power = 1'b1;
    req   = '0;
`ifdef HOT_WATER_ARB_URGENT_EN
    urgent = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    power = 1'b1;
    req   = '1;
`ifdef HOT_WATER_ARB_URGENT_EN
    urgent = '0;
`endif
    model_reset();
    #1;
    n_total++; if (grant !== '0) $display("FAIL reset_grant: got=%b exp=0", grant); else n_pass++;
    n_total++; if (heater_on !== 1'b0) $display("FAIL reset_heater: got=%b exp=0", heater_on); else n_pass++;
    n_total++; if (recovering !== 1'b0) $display("FAIL reset_recovering: got=%b exp=0", recovering); else n_pass++;
    n_total++; if (timeout_pulse !== '0) $display("FAIL reset_tp: got=%b exp=0", timeout_pulse); else n_pass++;
    n_total++; if (grant_id !== '0) $display("FAIL reset_grant_id: got=%0d exp=0", grant_id); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    cycle();
    n_total++; if (got !== exp_vec()) $display("FAIL reset_idle: got=%h exp=%h", got, exp_vec()); else n_pass++;
  endtask

  task automatic test_single();
    int hi = 0, rec = 0, tps = 0, first = -1;
    apply_reset();
    req = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) req = '0;
      cycle();
      n_total++;
      if (got !== exp_vec()) $display("FAIL single_model c=%0d: got=%h exp=%h", c, got, exp_vec());
      else n_pass++;
      if (grant == 4'b0001) begin hi++; if (first < 0) first = c; end
      if (recovering) rec++;
      if (timeout_pulse != '0) tps++;
    end
    n_total++; if (first !== 0) $display("FAIL single_latency: got=%0d exp=0", first); else n_pass++;
    n_total++; if (hi !== 5) $display("FAIL single_grant_len: got=%0d exp=5", hi); else n_pass++;
    n_total++; if (rec !== RC) $display("FAIL single_recover_len: got=%0d exp=%0d", rec, RC); else n_pass++;
    n_total++; if (tps !== 0) $display("FAIL single_tp: got=%0d exp=0", tps); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] prev = '0;
    int run = 0, low = 0, ng = 0;
    apply_reset();
    req = '1;
    for (int c = 0; c < 70; c++) begin
      cycle();
      n_total++;
      if (got !== exp_vec()) $display("FAIL rr_model c=%0d: got=%h exp=%h", c, got, exp_vec());
      else n_pass++;
      if (grant != '0) begin
        if (prev == '0) begin
          n_total++;
          if (grant !== (N'(1) << (ng % N))) $display("FAIL rr_order #%0d: got=%b exp=%b", ng, grant, N'(1) << (ng % N));
          else n_pass++;
          if (ng > 0) begin
            n_total++;
            if (low !== RC + 1) $display("FAIL rr_gap #%0d: got=%0d exp=%0d", ng, low, RC + 1); else n_pass++;
          end
          ng++;
          run = 0;
        end
        run++;
      end else begin
        if (prev != '0) begin
          n_total++; if (run !== MH) $display("FAIL rr_hold_len: got=%0d exp=%0d", run, MH); else n_pass++;
          n_total++; if (timeout_pulse !== prev) $display("FAIL rr_timeout_pulse: got=%b exp=%b", timeout_pulse, prev); else n_pass++;
          low = 0;
        end
        low++;
      end
      prev = grant;
    end
    n_total++; if (ng !== 5) $display("FAIL rr_grant_count: got=%0d exp=5", ng); else n_pass++;
  endtask

  task automatic test_release_at_limit();
    int hi = 0;
    apply_reset();
    req = 4'b0100;
    cycle();
    n_total++; if (grant !== 4'b0100) $display("FAIL lim_first_grant: got=%b exp=0100", grant); else n_pass++;
    hi = 1;
    repeat (9) begin
      cycle();
      if (grant == 4'b0100) hi++;
    end
    n_total++; if (hi !== MH) $display("FAIL lim_grant_len: got=%0d exp=%0d", hi, MH); else n_pass++;
    req = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_total++;
      if (timeout_pulse !== '0 || grant !== '0)
        $display("FAIL lim_release c=%0d: grant=%b tp=%b exp both 0", c, grant, timeout_pulse);
      else n_pass++;
      n_total++;
      if (got !== exp_vec()) $display("FAIL lim_model c=%0d: got=%h exp=%h", c, got, exp_vec()); else n_pass++;
    end
  endtask

  task automatic test_power();
    int waited = 0;
    apply_reset();
    req = '1;
    while (grant !== 4'b0100 && waited < 60) begin
      cycle();
      waited++;
    end
    n_total++; if (grant !== 4'b0100) $display("FAIL pwr_wait_grant2: got=%b exp=0100", grant); else n_pass++;
    repeat (2) cycle();
    power = 1'b0;
    cycle();
    n_total++;
    if (grant !== '0 || recovering !== 1'b0 || timeout_pulse !== '0)
      $display("FAIL pwr_off: grant=%b rec=%b tp=%b exp all 0", grant, recovering, timeout_pulse);
    else n_pass++;
    repeat (2) begin
      cycle();
      n_total++; if (got !== exp_vec()) $display("FAIL pwr_off_model: got=%h exp=%h", got, exp_vec()); else n_pass++;
    end
    power = 1'b1;
    cycle();
    n_total++; if (grant !== 4'b1000) $display("FAIL pwr_restore_grant: got=%b exp=1000", grant); else n_pass++;
    n_total++; if (grant_id !== 2'd3) $display("FAIL pwr_restore_id: got=%0d exp=3", grant_id); else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0001;
    repeat (3) cycle();
    req = '0;
    cycle();
    n_total++; if (recovering !== 1'b1) $display("FAIL arst_in_recover: got=%b exp=1", recovering); else n_pass++;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (got !== '0) $display("FAIL arst_outputs: got=%h exp=0", got); else n_pass++;
    #2;
    rst = 1'b1;
    req = 4'b0010;
    cycle();
    n_total++; if (grant !== 4'b0010) $display("FAIL arst_regrant: got=%b exp=0010", grant); else n_pass++;
    n_total++; if (got !== exp_vec()) $display("FAIL arst_model: got=%h exp=%h", got, exp_vec()); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      power = ($urandom_range(0, 24) != 0);
`ifdef HOT_WATER_ARB_URGENT_EN
      if ($urandom_range(0, 15) == 0) urgent = N'($urandom);
`endif
      cycle();
      n_total++;
      if (got !== exp_vec()) $display("FAIL random_model c=%0d: got=%h exp=%h", c, got, exp_vec());
      else n_pass++;
    end
    power = 1'b1;
  endtask

`ifdef HOT_WATER_ARB_URGENT_EN
  task automatic test_urgent();
    int run = 0;
    apply_reset();
    req    = '1;
    urgent = 4'b0100;
    cycle();
    n_total++; if (grant !== 4'b0100) $display("FAIL urg_first: got=%b exp=0100", grant); else n_pass++;
    while (grant == 4'b0100 && run < 30) begin
      run++;
      cycle();
      n_total++; if (got !== exp_vec()) $display("FAIL urg_model: got=%h exp=%h", got, exp_vec()); else n_pass++;
    end
    n_total++; if (run !== 2 * MH) $display("FAIL urg_hold_len: got=%0d exp=%0d", run, 2 * MH); else n_pass++;
    n_total++; if (timeout_pulse !== 4'b0100) $display("FAIL urg_tp: got=%b exp=0100", timeout_pulse); else n_pass++;
    urgent = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_release_at_limit();
    test_power();
    test_async_reset();
`ifdef HOT_WATER_ARB_URGENT_EN
    test_urgent();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
